// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch port: request/address out, ack/data back.
interface instr_sequencer_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle RV32 sequencer: FETCH -> DECODE -> EXEC -> WB, one instruction at a time.
// Owns the instruction register, PC, retired counter and datapath strobes.
module instr_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  instr_sequencer_if.master   imem,
  output logic [31:0]         inst,
  output logic [31:0]         pc,
  output logic                alu_src_imm,
  output logic                rf_we,
  output logic                busy,
  output logic                halted,
  output logic                illegal,
  output logic [31:0]         retired
);
  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 7;
  localparam logic [OP_W-1:0] OP_REG = 7'h33;
  localparam logic [OP_W-1:0] OP_IMM = 7'h13;
  localparam logic [OP_W-1:0] OP_SYS = 7'h73;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] retired_q, retired_d;
  logic            alu_imm_q, alu_imm_d;
  logic            illegal_q, illegal_d;
  logic            req_q, req_d;
  logic            rf_we_q, rf_we_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      retired_q <= '0;
      alu_imm_q <= 1'b0;
      illegal_q <= 1'b0;
      req_q     <= 1'b0;
      rf_we_q   <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
      alu_imm_q <= alu_imm_d;
      illegal_q <= illegal_d;
      req_q     <= req_d;
      rf_we_q   <= rf_we_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    retired_d = retired_q;
    alu_imm_d = alu_imm_q;
    illegal_d = illegal_q;

    unique case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (imem.imem_ack) begin
          inst_d  = imem.imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (inst_q[OP_W-1:0])
          OP_REG: begin alu_imm_d = 1'b0; state_d = S_EXEC; end
          OP_IMM: begin alu_imm_d = 1'b1; state_d = S_EXEC; end
          OP_SYS: state_d = S_HALT;
          default: begin illegal_d = 1'b1; state_d = S_HALT; end
        endcase
      end
      S_EXEC:   state_d = S_WB;
      S_WB: begin
        pc_d      = pc_q + PC_STEP;
        retired_d = retired_q + XLEN'(1);
        state_d   = run ? S_FETCH : S_IDLE;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase

    // Strobes are registered from the next state so they line up with the state they describe.
    req_d    = (state_d == S_FETCH);
    busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) ||
               (state_d == S_EXEC)  || (state_d == S_WB);
    halted_d = (state_d == S_HALT);
    rf_we_d  = (state_d == S_WB) && (inst_d[11:7] != 5'd0);
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign alu_src_imm    = alu_imm_q;
  assign rf_we          = rf_we_q;
  assign busy           = busy_q;
  assign halted         = halted_q;
  assign illegal        = illegal_q;
  assign retired        = retired_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: fetch/decode/wb timing, halts, run control, reset, pc wrap.
module tb_instr_sequencer;
  logic        clk = 1'b0;
  logic        rst, run, rst_w, run_w;
  logic [31:0] inst, pc, retired, inst_w, pc_w, retired_w;
  logic        alu_src_imm, rf_we, busy, halted, illegal;
  logic        alu_w, rf_we_w, busy_w, halted_w, illegal_w;
  int          checks = 0;
  int          errors = 0;

  instr_sequencer_if bus ();
  instr_sequencer_if bus_w ();

  instr_sequencer u_dut (
    .clk(clk), .rst(rst), .run(run), .imem(bus.master),
    .inst(inst), .pc(pc), .alu_src_imm(alu_src_imm), .rf_we(rf_we),
    .busy(busy), .halted(halted), .illegal(illegal), .retired(retired)
  );

  instr_sequencer #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) u_wrap (
    .clk(clk), .rst(rst_w), .run(run_w), .imem(bus_w.master),
    .inst(inst_w), .pc(pc_w), .alu_src_imm(alu_w), .rf_we(rf_we_w),
    .busy(busy_w), .halted(halted_w), .illegal(illegal_w), .retired(retired_w)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0050_0093;
    step(); step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp %h", pc, 32'h0); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h exp %h", inst, 32'h0); end
    checks++; if (retired !== 32'h0) begin errors++; $display("FAIL reset_retired: got %h exp 0", retired); end
    checks++; if ({bus.imem_req, rf_we, alu_src_imm, busy, halted, illegal} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b exp 000000", {bus.imem_req, rf_we, alu_src_imm, busy, halted, illegal});
    end
    rst = 1'b0; run = 1'b0; bus.imem_ack = 1'b0;
  endtask

  task automatic test_addi();
    do_reset();
    run = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0050_0093;
    step(); // FETCH
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL addi_fetch: req %b addr %h exp 1 00000000", bus.imem_req, bus.imem_addr);
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL addi_busy: got %b exp 1", busy); end
    step(); // DECODE
    checks++; if (inst !== 32'h0050_0093 || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL addi_inst: inst %h req %b exp 00500093 0", inst, bus.imem_req);
    end
    step(); // EXEC
    checks++; if (alu_src_imm !== 1'b1 || rf_we !== 1'b0) begin
      errors++; $display("FAIL addi_exec: alu %b rf_we %b exp 1 0", alu_src_imm, rf_we);
    end
    step(); // WB
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL addi_rf_we: got %b exp 1", rf_we); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL addi_pc_in_wb: got %h exp 0", pc); end
    run = 1'b0;
    step(); // IDLE
    checks++; if (pc !== 32'h4 || retired !== 32'h1) begin
      errors++; $display("FAIL addi_retire: pc %h retired %h exp 4 1", pc, retired);
    end
    checks++; if (rf_we !== 1'b0 || busy !== 1'b0 || bus.imem_req !== 1'b0 || alu_src_imm !== 1'b1) begin
      errors++; $display("FAIL addi_idle: rf_we %b busy %b req %b alu %b exp 0 0 0 1", rf_we, busy, bus.imem_req, alu_src_imm);
    end
    step(); // ack held high while idle must be ignored
    checks++; if (busy !== 1'b0 || pc !== 32'h4) begin
      errors++; $display("FAIL addi_ack_idle: busy %b pc %h exp 0 4", busy, pc);
    end
    bus.imem_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    do_reset();
    run = 1'b1; bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0020_81B3;
    step(); // FETCH of instruction 0
    for (int i = 0; i < 3; i++) begin
      cyc = 0;
      for (int w = 0; w < 3; w++) begin
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(i * 4)) begin
          errors++; $display("FAIL b2b_wait%0d_%0d: req %b addr %h exp 1 %h", i, w, bus.imem_req, bus.imem_addr, 32'(i * 4));
        end
        step(); cyc++;
      end
      bus.imem_ack = 1'b1;
      step(); cyc++; // DECODE
      bus.imem_ack = 1'b0;
      checks++; if (inst !== 32'h0020_81B3) begin errors++; $display("FAIL b2b_inst%0d: got %h exp 002081b3", i, inst); end
      step(); cyc++; // EXEC
      checks++; if (alu_src_imm !== 1'b0) begin errors++; $display("FAIL b2b_alu%0d: got %b exp 0", i, alu_src_imm); end
      step(); cyc++; // WB
      checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL b2b_rf_we%0d: got %b exp 1", i, rf_we); end
      step(); cyc++; // next FETCH
      checks++; if (cyc !== 7 || bus.imem_req !== 1'b1) begin
        errors++; $display("FAIL b2b_cycles%0d: cycles %0d req %b exp 7 1", i, cyc, bus.imem_req);
      end
    end
    checks++; if (pc !== 32'hC || retired !== 32'd3) begin
      errors++; $display("FAIL b2b_final: pc %h retired %h exp c 3", pc, retired);
    end
  endtask

  task automatic test_x0_write();
    do_reset();
    run = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0013;
    step(); step(); step(); // FETCH, DECODE, EXEC
    bus.imem_ack = 1'b0;
    checks++; if (alu_src_imm !== 1'b1) begin errors++; $display("FAIL x0_alu: got %b exp 1", alu_src_imm); end
    step(); // WB
    checks++; if (rf_we !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL x0_rf_we: rf_we %b busy %b exp 0 1", rf_we, busy);
    end
    run = 1'b0;
    step();
    checks++; if (pc !== 32'h4 || retired !== 32'h1) begin
      errors++; $display("FAIL x0_retire: pc %h retired %h exp 4 1", pc, retired);
    end
  endtask

  task automatic test_halt(input logic [31:0] word, input logic exp_illegal);
    do_reset();
    run = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = word;
    step(); step(); // FETCH, DECODE
    checks++; if (halted !== 1'b0 || illegal !== 1'b0) begin
      errors++; $display("FAIL halt_early_%h: halted %b illegal %b exp 0 0", word, halted, illegal);
    end
    bus.imem_rdata = 32'h0050_0093;
    step(); // HALT
    checks++; if (halted !== 1'b1 || illegal !== exp_illegal || busy !== 1'b0) begin
      errors++; $display("FAIL halt_enter_%h: halted %b illegal %b busy %b exp 1 %b 0", word, halted, illegal, busy, exp_illegal);
    end
    checks++; if (pc !== 32'h0 || retired !== 32'h0) begin
      errors++; $display("FAIL halt_pc_%h: pc %h retired %h exp 0 0", word, pc, retired);
    end
    for (int k = 0; k < 4; k++) begin
      run = k[0]; bus.imem_ack = ~k[1];
      step();
    end
    checks++; if (halted !== 1'b1 || illegal !== exp_illegal || bus.imem_req !== 1'b0 || inst !== word || rf_we !== 1'b0) begin
      errors++; $display("FAIL halt_sticky_%h: halted %b illegal %b req %b inst %h rf_we %b", word, halted, illegal, bus.imem_req, inst, rf_we);
    end
    bus.imem_ack = 1'b0; run = 1'b0;
  endtask

  task automatic test_run_drop();
    do_reset();
    run = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0050_0093;
    step(); step(); step(); // FETCH, DECODE, EXEC
    run = 1'b0;
    step(); // WB
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL drop_rf_we: got %b exp 1", rf_we); end
    step(); step(); // IDLE, IDLE
    checks++; if (busy !== 1'b0 || bus.imem_req !== 1'b0 || pc !== 32'h4 || rf_we !== 1'b0) begin
      errors++; $display("FAIL drop_idle: busy %b req %b pc %h rf_we %b exp 0 0 4 0", busy, bus.imem_req, pc, rf_we);
    end
    run = 1'b1; bus.imem_ack = 1'b0;
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || busy !== 1'b1) begin
      errors++; $display("FAIL drop_refetch: req %b addr %h busy %b exp 1 4 1", bus.imem_req, bus.imem_addr, busy);
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    run = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0050_0093;
    step(); step(); step(); step(); // FETCH, DECODE, EXEC, WB
    bus.imem_ack = 1'b0;
    step(); // FETCH at pc 4
    checks++; if (pc !== 32'h4 || retired !== 32'h1 || bus.imem_req !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: pc %h retired %h req %b exp 4 1 1", pc, retired, bus.imem_req);
    end
    rst = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_007F;
    step();
    rst = 1'b0; run = 1'b0; bus.imem_ack = 1'b0;
    checks++; if (pc !== 32'h0 || inst !== 32'h0 || retired !== 32'h0) begin
      errors++; $display("FAIL rstmid_regs: pc %h inst %h retired %h exp 0 0 0", pc, inst, retired);
    end
    checks++; if ({bus.imem_req, rf_we, alu_src_imm, busy, halted, illegal} !== 6'b0) begin
      errors++; $display("FAIL rstmid_flags: got %b exp 000000", {bus.imem_req, rf_we, alu_src_imm, busy, halted, illegal});
    end
  endtask

  task automatic test_pc_wrap();
    checks++; if (pc_w !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_reset_pc: got %h exp fffffffc", pc_w); end
    rst_w = 1'b0; run_w = 1'b1;
    step(); // FETCH
    checks++; if (bus_w.imem_addr !== 32'hFFFF_FFFC || bus_w.imem_req !== 1'b1) begin
      errors++; $display("FAIL wrap_fetch: addr %h req %b exp fffffffc 1", bus_w.imem_addr, bus_w.imem_req);
    end
    step(); step(); step(); // DECODE, EXEC, WB
    checks++; if (rf_we_w !== 1'b1) begin errors++; $display("FAIL wrap_rf_we: got %b exp 1", rf_we_w); end
    run_w = 1'b0;
    step();
    checks++; if (pc_w !== 32'h0 || retired_w !== 32'h1) begin
      errors++; $display("FAIL wrap_pc: pc %h retired %h exp 0 1", pc_w, retired_w);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    rst_w = 1'b1; run_w = 1'b0; bus_w.imem_ack = 1'b1; bus_w.imem_rdata = 32'h0050_0093;
    step();
    test_reset();
    test_addi();
    test_back_to_back();
    test_x0_write();
    test_halt(32'h0000_007F, 1'b1);
    test_halt(32'h0000_0073, 1'b0);
    test_run_drop();
    test_reset_mid_fetch();
    test_pc_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle sequencer that drives the RV32 integer datapath one instruction at a time. It fetches from instruction memory over a req/ack handshake, holds the instruction register that feeds the decode unit, and steps FETCH -> DECODE -> EXEC -> WB. It also generates register-file write enable and ALU operand-select strobes, advances the PC, and counts retired instructions. It sits between instruction memory and the decode/ALU/register-file datapath.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- PC_STEP, 4, PC increment per retired instruction.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; 1 permits fetching of new instructions.
- imem_req  out  1  fetch request, valid in FETCH.
- imem_addr  out  32  fetch address, always equal to pc.
- imem_ack  in  1  imem_rdata valid this cycle; honoured only while imem_req=1.
- imem_rdata  in  32  fetched instruction word.
- inst  out  32  instruction register, drives decode unit.
- pc  out  32  address of current instruction.
- alu_src_imm  out  1  1 = ALU operand B is immediate (opcode 0x13), 0 = rs2 (opcode 0x33).
- rf_we  out  1  register-file write strobe, one cycle in WB.
- busy  out  1  1 in FETCH/DECODE/EXEC/WB.
- halted  out  1  sticky; 1 in HALT.
- illegal  out  1  sticky; 1 if halt cause was unsupported opcode.
- retired  out  32  retired-instruction counter.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- Reset (rst=1 at an edge, any state): state=IDLE, pc=RESET_PC, inst=0, imem_req=0, rf_we=0, alu_src_imm=0, halted=0, illegal=0, retired=0. An ack in the same cycle is discarded. Reset has priority over every other event.
- IDLE: if run=1, go to FETCH; otherwise stay.
- FETCH: imem_req=1, imem_addr=pc held stable. On imem_ack=1: inst<=imem_rdata and go to DECODE. Otherwise stay, with no timeout.
- DECODE: classify inst[6:0]:
  - 0x33: alu_src_imm<=0, go to EXEC.
  - 0x13: alu_src_imm<=1, go to EXEC.
  - 0x73: go to HALT with illegal=0. pc and retired are unchanged.
  - Any other opcode, including an all-zero word: go to HALT with illegal<=1. pc and retired are unchanged.
- EXEC: one cycle for ALU settle, then go to WB.
- WB:
  - rf_we=1 only if inst[11:7]!=0. No write to x0 is ever strobed.
  - pc<=pc+PC_STEP (32-bit, wraps 0xFFFF_FFFC -> 0x0000_0000).
  - retired<=retired+1 (wraps at 2^32).
  - Next state is FETCH if run=1, otherwise IDLE.
- HALT: halted=1. Stays until rst. run is ignored.
- run deasserted mid-instruction: the current instruction completes through WB, then the block enters IDLE.
- imem_ack while imem_req=0: ignored; no state change.
- alu_src_imm holds its DECODE value through EXEC and WB until the next DECODE.
- inst holds until the next accepted ack.

## Timing
- All outputs are registered or decoded from state only; no combinational path from imem_ack or imem_rdata to any output.
- Fetch with zero-wait ack: 4 cycles per instruction (FETCH, DECODE, EXEC, WB). Each ack wait cycle adds 1.
- imem_req rises in the first cycle after entering FETCH and falls the cycle after the ack edge.
- rf_we is high for exactly one cycle per eligible instruction, in the cycle before the next FETCH or IDLE. The register file samples at the rising edge that ends WB.
- pc and retired update at the edge leaving WB. The new pc is visible on imem_addr in the following FETCH.
- halted and illegal assert in the cycle after the DECODE edge.
- busy=0 in IDLE and HALT.

## Test plan
- Reset then run=1, ack every cycle, imem_rdata=0x00500093 (addi x1,x0,5) -> imem_addr=0, inst=0x00500093, alu_src_imm=1, rf_we pulses once at cycle 4, pc=4, retired=1.
- Stream of 0x002081B3 (add x3,x1,x2) with ack delayed 3 cycles each -> 7 cycles/instr, alu_src_imm=0, imem_addr stable during wait, pc steps 0,4,8.
- Instruction 0x00000013 (addi x0,x0,0) -> no rf_we pulse; pc=4, retired=1.
- Opcode 0x7F word then 0x00000073 case (separate runs) -> first: halted=1, illegal=1, pc=0, retired=0; second: halted=1, illegal=0; further acks and run toggles have no effect.
- run dropped during EXEC -> WB completes (rf_we pulse, pc+4), then IDLE with busy=0; run re-raised -> FETCH at new pc.
- rst asserted mid-FETCH with simultaneous ack; separately pc preset near 0xFFFF_FFFC -> reset returns all outputs to reset values next cycle; wrap case gives pc=0 after WB.
